// File: rtl/realtanksoc_busmtx_slave_arbiter_pkg.sv
// Shared AHB bus-matrix encodings (HTRANS/HRESP) and small decode helpers,
// common to the slave-port arbiters and the default slave.
package realtanksoc_busmtx_slave_arbiter_pkg;

   localparam int MST_IDX_W = 2;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01,
      HRESP_RETRY = 2'b10,
      HRESP_SPLIT = 2'b11
   } hresp_t;

   // NONSEQ/SEQ carry a data phase; IDLE/BUSY do not.
   function automatic logic trans_has_data(input htrans_t t);
      return t[1];
   endfunction

   // SEQ/BUSY mean the owner is mid-burst and must keep the address phase.
   function automatic logic trans_in_burst(input htrans_t t);
      return (t == HTRANS_SEQ) || (t == HTRANS_BUSY);
   endfunction

endpackage

// File: rtl/realtanksoc_busmtx_slave_arbiter_if.sv
// Request/grant bundle between the master input stages and one slave-port arbiter.
interface realtanksoc_busmtx_slave_arbiter_if
   import realtanksoc_busmtx_slave_arbiter_pkg::*;
#(
   parameter int NUM_MST = 2,
   parameter int MST_W   = 2
);
   logic [NUM_MST-1:0] REQ;
   logic [NUM_MST-1:0] LOCK;
   htrans_t            HTRANS_SEL;
   logic               HREADYM;
   logic [NUM_MST-1:0] ADDR_GNT;
   logic               ADDR_ACTIVE;
   logic [MST_W-1:0]   ADDR_MST;
   logic [NUM_MST-1:0] DATA_GNT;
   logic               DATA_ACTIVE;

   // Arbiter side.
   modport slave (
      input  REQ, LOCK, HTRANS_SEL, HREADYM,
      output ADDR_GNT, ADDR_ACTIVE, ADDR_MST, DATA_GNT, DATA_ACTIVE
   );

   // Requesting input-stage side.
   modport master (
      output REQ, LOCK, HTRANS_SEL, HREADYM,
      input  ADDR_GNT, ADDR_ACTIVE, ADDR_MST, DATA_GNT, DATA_ACTIVE
   );
endinterface

// File: rtl/realtanksoc_rr_pick.sv
// Combinational round-robin pick: first set request after ptr, wrapping modulo NUM_MST.
module realtanksoc_rr_pick #(
   parameter int NUM_MST = 2,
   parameter int MST_W   = 2
) (
   input  logic [NUM_MST-1:0] req,
   input  logic [MST_W-1:0]   ptr,
   output logic [NUM_MST-1:0] gnt,
   output logic [MST_W-1:0]   idx,
   output logic               found
);
   localparam int PAD_W = 1 << MST_W;

   logic [PAD_W-1:0] req_pad;
   logic [MST_W-1:0] cand;

   assign req_pad = PAD_W'(req);

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no latch is inferred.
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = 1; k <= NUM_MST; k++) begin
         cand = MST_W'((int'(ptr) + k) % NUM_MST);
         if (!found && req_pad[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      gnt = found ? (NUM_MST'(1) << idx) : '0;
   end
endmodule

// File: rtl/realtanksoc_busmtx_slave_arbiter.sv
// Slave-port arbiter: round-robin address-phase ownership with burst/lock hold,
// plus the data-phase owner that steers the slave response back.
module realtanksoc_busmtx_slave_arbiter
   import realtanksoc_busmtx_slave_arbiter_pkg::*;
#(
   parameter int NUM_MST = 2,
   parameter int MST_W   = 2
) (
   input logic HCLK,
   input logic HRESETn,
   realtanksoc_busmtx_slave_arbiter_if.slave bus
);
   logic [NUM_MST-1:0] addr_gnt_q, addr_gnt_d;
   logic [MST_W-1:0]   addr_mst_q, addr_mst_d;
   logic [NUM_MST-1:0] data_gnt_q, data_gnt_d;
   logic [MST_W-1:0]   ptr_q, ptr_d;
   logic               locked_q, locked_d;

   logic [NUM_MST-1:0] pick_gnt;
   logic [MST_W-1:0]   pick_idx;
   logic               pick_found;
   logic               owner_req, owner_lock, lock_hold, hold;

   realtanksoc_rr_pick #(.NUM_MST(NUM_MST), .MST_W(MST_W)) u_pick (
      .req   (bus.REQ),
      .ptr   (ptr_q),
      .gnt   (pick_gnt),
      .idx   (pick_idx),
      .found (pick_found)
   );

   assign owner_req  = |(bus.REQ  & addr_gnt_q);
   assign owner_lock = |(bus.LOCK & addr_gnt_q);
   // The locked flag carries a locked sequence across IDLE gaps where REQ drops,
   // but it never outlives the owner's LOCK.
   assign lock_hold  = owner_lock & (owner_req | locked_q);
   assign hold       = (|addr_gnt_q) & (trans_in_burst(bus.HTRANS_SEL) | lock_hold);

   always_comb begin
      addr_gnt_d = addr_gnt_q;
      addr_mst_d = addr_mst_q;
      ptr_d      = ptr_q;
      locked_d   = lock_hold;
      if (!hold) begin
         addr_gnt_d = pick_gnt;
         locked_d   = |(bus.LOCK & bus.REQ & pick_gnt);
         if (pick_found) begin
            addr_mst_d = pick_idx;
            ptr_d      = pick_idx;
         end
      end
      data_gnt_d = trans_has_data(bus.HTRANS_SEL) ? addr_gnt_q : '0;
   end

   // HREADYM low is a wait state: both phases stretch, so nothing moves.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         // NOTE: sequential state uses non-blocking assignments only.
         addr_gnt_q <= '0;
         addr_mst_q <= '0;
         data_gnt_q <= '0;
         ptr_q      <= MST_W'(NUM_MST - 1);
         locked_q   <= 1'b0;
      end else if (bus.HREADYM) begin
         addr_gnt_q <= addr_gnt_d;
         addr_mst_q <= addr_mst_d;
         data_gnt_q <= data_gnt_d;
         ptr_q      <= ptr_d;
         locked_q   <= locked_d;
      end
   end

   assign bus.ADDR_GNT    = addr_gnt_q;
   assign bus.ADDR_ACTIVE = |addr_gnt_q;
   assign bus.ADDR_MST    = addr_mst_q;
   assign bus.DATA_GNT    = data_gnt_q;
   assign bus.DATA_ACTIVE = |data_gnt_q;
endmodule

// File: tb/tb_realtanksoc_busmtx_slave_arbiter.sv
// Scoreboard bench: directed steps push hand-computed grants, a negedge monitor checks them.
module tb_realtanksoc_busmtx_slave_arbiter;
   import realtanksoc_busmtx_slave_arbiter_pkg::*;

   logic HCLK;
   logic HRESETn;

   realtanksoc_busmtx_slave_arbiter_if #(.NUM_MST(2), .MST_W(2)) if2 ();
   realtanksoc_busmtx_slave_arbiter_if #(.NUM_MST(3), .MST_W(2)) if3 ();

   realtanksoc_busmtx_slave_arbiter #(.NUM_MST(2), .MST_W(2)) u_dut2 (
      .HCLK(HCLK), .HRESETn(HRESETn), .bus(if2.slave));
   realtanksoc_busmtx_slave_arbiter #(.NUM_MST(3), .MST_W(2)) u_dut3 (
      .HCLK(HCLK), .HRESETn(HRESETn), .bus(if3.slave));

   typedef struct {
      int         dut;
      string      name;
      logic [3:0] agnt;
      logic [1:0] mst;
      logic [3:0] dgnt;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got {agnt,aact,mst,dgnt,dact}=%b required %b", name, act, req);
      end
   endtask

   task automatic push_exp(input int dut, input string name, input logic [3:0] eag,
                           input logic [1:0] em, input logic [3:0] edg);
      exp_t e;
      e.dut  = dut;
      e.name = name;
      e.agnt = eag;
      e.mst  = em;
      e.dgnt = edg;
      sb_q.push_back(e);
   endtask

   // Drive one accepted (or stalled) cycle and queue what the outputs must be after it.
   task automatic step(input int dut, input logic [3:0] req, input logic [3:0] lock,
                       input htrans_t tr, input logic hr, input logic [3:0] eag,
                       input logic [1:0] em, input logic [3:0] edg, input string name);
      @(negedge HCLK);
      if (dut == 2) begin
         if2.REQ = req[1:0]; if2.LOCK = lock[1:0]; if2.HTRANS_SEL = tr; if2.HREADYM = hr;
      end else begin
         if3.REQ = req[2:0]; if3.LOCK = lock[2:0]; if3.HTRANS_SEL = tr; if3.HREADYM = hr;
      end
      @(posedge HCLK);
      push_exp(dut, name, eag, em, edg);
   endtask

   // Monitor: every negedge, compare all pending expectations against the DUT.
   initial begin
      exp_t e;
      logic [11:0] act;
      logic [11:0] req;
      forever begin
         @(negedge HCLK);
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.dut == 2)
               act = {2'b00, if2.ADDR_GNT, if2.ADDR_ACTIVE, if2.ADDR_MST,
                      2'b00, if2.DATA_GNT, if2.DATA_ACTIVE};
            else
               act = {1'b0, if3.ADDR_GNT, if3.ADDR_ACTIVE, if3.ADDR_MST,
                      1'b0, if3.DATA_GNT, if3.DATA_ACTIVE};
            req = {e.agnt, |e.agnt, e.mst, e.dgnt, |e.dgnt};
            check(e.name, act, req);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      HRESETn = 1'b0;
      if2.REQ = '0; if2.LOCK = '0; if2.HTRANS_SEL = HTRANS_IDLE; if2.HREADYM = 1'b1;
      if3.REQ = '0; if3.LOCK = '0; if3.HTRANS_SEL = HTRANS_IDLE; if3.HREADYM = 1'b1;
      push_exp(2, "reset2", 4'b0000, 2'd0, 4'b0000);
      push_exp(3, "reset3", 4'b0000, 2'd0, 4'b0000);
      @(negedge HCLK);
      #1 HRESETn = 1'b1;

      // Two-master alternation (pointer starts at 1, so master 0 wins first).
      step(2, 4'b11, 4'b00, HTRANS_NONSEQ, 1'b1, 4'b01, 2'd0, 4'b00, "rr_c1");
      step(2, 4'b11, 4'b00, HTRANS_NONSEQ, 1'b1, 4'b10, 2'd1, 4'b01, "rr_c2");
      step(2, 4'b11, 4'b00, HTRANS_NONSEQ, 1'b1, 4'b01, 2'd0, 4'b10, "rr_c3");
      step(2, 4'b11, 4'b00, HTRANS_NONSEQ, 1'b1, 4'b10, 2'd1, 4'b01, "rr_c4");
      step(2, 4'b11, 4'b00, HTRANS_NONSEQ, 1'b1, 4'b01, 2'd0, 4'b10, "rr_c5");
      // Burst hold on master 0, then release on NONSEQ.
      step(2, 4'b11, 4'b00, HTRANS_SEQ,    1'b1, 4'b01, 2'd0, 4'b01, "seq_b1");
      step(2, 4'b11, 4'b00, HTRANS_SEQ,    1'b1, 4'b01, 2'd0, 4'b01, "seq_b2");
      step(2, 4'b11, 4'b00, HTRANS_SEQ,    1'b1, 4'b01, 2'd0, 4'b01, "seq_b3");
      step(2, 4'b11, 4'b00, HTRANS_NONSEQ, 1'b1, 4'b10, 2'd1, 4'b01, "seq_end");
      // BUSY holds the owner but has no data phase.
      step(2, 4'b11, 4'b00, HTRANS_BUSY,   1'b1, 4'b10, 2'd1, 4'b00, "busy_hold");
      step(2, 4'b11, 4'b00, HTRANS_NONSEQ, 1'b1, 4'b01, 2'd0, 4'b10, "busy_end");
      // Wait states freeze everything.
      step(2, 4'b10, 4'b00, HTRANS_NONSEQ, 1'b0, 4'b01, 2'd0, 4'b10, "wait1");
      step(2, 4'b10, 4'b00, HTRANS_NONSEQ, 1'b0, 4'b01, 2'd0, 4'b10, "wait2");
      step(2, 4'b10, 4'b00, HTRANS_NONSEQ, 1'b0, 4'b01, 2'd0, 4'b10, "wait3");
      step(2, 4'b10, 4'b00, HTRANS_NONSEQ, 1'b0, 4'b01, 2'd0, 4'b10, "wait4");
      step(2, 4'b10, 4'b00, HTRANS_NONSEQ, 1'b1, 4'b10, 2'd1, 4'b01, "wait_rel");
      // Owner drops REQ mid-burst: hold survives until IDLE, then park on master 1.
      step(2, 4'b00, 4'b00, HTRANS_SEQ,    1'b1, 4'b10, 2'd1, 4'b10, "reqdrop_seq");
      step(2, 4'b00, 4'b00, HTRANS_IDLE,   1'b1, 4'b00, 2'd1, 4'b00, "park_idle");
      // Locked sequence on master 0.
      step(2, 4'b11, 4'b01, HTRANS_NONSEQ, 1'b1, 4'b01, 2'd0, 4'b00, "lock_gnt");
      step(2, 4'b11, 4'b01, HTRANS_NONSEQ, 1'b1, 4'b01, 2'd0, 4'b01, "lock_h1");
      step(2, 4'b11, 4'b01, HTRANS_NONSEQ, 1'b1, 4'b01, 2'd0, 4'b01, "lock_h2");
      step(2, 4'b11, 4'b00, HTRANS_NONSEQ, 1'b1, 4'b10, 2'd1, 4'b01, "lock_rel");
      // Locked flag carries the owner across an IDLE gap where its REQ drops.
      step(2, 4'b11, 4'b01, HTRANS_NONSEQ, 1'b1, 4'b01, 2'd0, 4'b10, "lflag_gnt");
      step(2, 4'b10, 4'b01, HTRANS_IDLE,   1'b1, 4'b01, 2'd0, 4'b00, "lflag_idle");
      step(2, 4'b10, 4'b00, HTRANS_NONSEQ, 1'b1, 4'b10, 2'd1, 4'b01, "lflag_rel");
      // Sole requester is re-granted.
      step(2, 4'b10, 4'b00, HTRANS_NONSEQ, 1'b1, 4'b10, 2'd1, 4'b10, "regrant");
      step(2, 4'b00, 4'b00, HTRANS_IDLE,   1'b1, 4'b00, 2'd1, 4'b00, "idle2");

      // Three masters, pointer still at its reset value 2.
      step(3, 4'b101, 4'b000, HTRANS_NONSEQ, 1'b1, 4'b001, 2'd0, 4'b000, "m3_wrap");
      step(3, 4'b011, 4'b000, HTRANS_NONSEQ, 1'b1, 4'b010, 2'd1, 4'b001, "m3_next");
      step(3, 4'b100, 4'b000, HTRANS_NONSEQ, 1'b1, 4'b100, 2'd2, 4'b010, "m3_top");
      step(3, 4'b011, 4'b000, HTRANS_NONSEQ, 1'b1, 4'b001, 2'd0, 4'b100, "m3_wrap2");
      step(3, 4'b111, 4'b000, HTRANS_SEQ,    1'b1, 4'b001, 2'd0, 4'b001, "m3_burst");

      // Asynchronous reset in the middle of the burst, away from any rising edge.
      @(negedge HCLK);
      @(posedge HCLK);
      #2;
      HRESETn = 1'b0;
      if3.REQ = '0; if3.HTRANS_SEL = HTRANS_IDLE;
      push_exp(3, "async_rst", 4'b000, 2'd0, 4'b000);
      @(negedge HCLK);
      #1 HRESETn = 1'b1;
      step(3, 4'b111, 4'b000, HTRANS_NONSEQ, 1'b1, 4'b001, 2'd0, 4'b000, "post_rst");

      @(negedge HCLK);
      @(negedge HCLK);
      check("sb_drain", 12'(sb_q.size()), 12'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
